// File: rtl/robot_controller.sv
// Obstacle-avoidance motion controller: a Moore FSM turns a distance reading into
// speed, direction and turn commands for the motor PWM stage.
module robot_controller #(
    parameter logic [15:0] SLOW_TH     = 16'd1000,
    parameter logic [15:0] STOP_TH     = 16'd300,
    parameter int          REV_CYCLES  = 4,
    parameter int          TURN_CYCLES = 8,
    parameter logic [7:0]  FULL_SPD    = 8'd255,
    parameter logic [7:0]  SLOW_SPD    = 8'd128
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] dist_v,
    output logic [2:0]  state,
    output logic [7:0]  speed,
    output logic        dir,
    output logic        turn,
    output logic        obstacle,
    output logic [7:0]  stop_cnt
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FWD  = 3'd1,
        S_SLOW = 3'd2,
        S_STOP = 3'd3,
        S_REV  = 3'd4,
        S_TURN = 3'd5
    } state_t;

    localparam logic [7:0] REV_LOAD  = 8'(REV_CYCLES - 1);
    localparam logic [7:0] TURN_LOAD = 8'(TURN_CYCLES - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [7:0] r_speed;
    logic       r_dir;
    logic       r_turn;
    logic       r_obstacle;
    logic [7:0] r_stop_cnt;
    state_t     w_next_state;
    logic [7:0] w_next_cnt;
    logic       w_stop;
    logic       w_slow;

    function automatic logic [7:0] f_speed(input state_t s);
        case (s)
            S_FWD:                  return FULL_SPD;
            S_SLOW, S_REV, S_TURN:  return SLOW_SPD;
            default:                return 8'd0;
        endcase
    endfunction

    assign w_stop = (dist_v < STOP_TH);
    assign w_slow = (dist_v < SLOW_TH);

    // Next-state and dwell-counter logic; stop has priority over slow.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_IDLE: w_next_state = S_FWD;
            S_FWD: begin
                if (w_stop)      w_next_state = S_STOP;
                else if (w_slow) w_next_state = S_SLOW;
                else             w_next_state = S_FWD;
            end
            S_SLOW: begin
                if (w_stop)       w_next_state = S_STOP;
                else if (!w_slow) w_next_state = S_FWD;
                else              w_next_state = S_SLOW;
            end
            S_STOP: begin
                w_next_state = S_REV;
                w_next_cnt   = REV_LOAD;
            end
            S_REV: begin
                if (r_cnt != 8'd0) begin
                    w_next_cnt = r_cnt - 8'd1;
                end else begin
                    w_next_state = S_TURN;
                    w_next_cnt   = TURN_LOAD;
                end
            end
            S_TURN: begin
                if (r_cnt != 8'd0) w_next_cnt = r_cnt - 8'd1;
                else if (!w_slow)  w_next_state = S_FWD;
                else if (!w_stop)  w_next_state = S_SLOW;
                else               w_next_cnt = TURN_LOAD;
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = 8'd0;
            end
        endcase
    end

    // State, counter and outputs; outputs are decoded from the next state so they track the state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_speed    <= 8'd0;
            r_dir      <= 1'b1;
            r_turn     <= 1'b0;
            r_obstacle <= 1'b0;
            r_stop_cnt <= 8'd0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_next_cnt;
            r_speed    <= f_speed(w_next_state);
            r_dir      <= (w_next_state != S_REV);
            r_turn     <= (w_next_state == S_TURN);
            r_obstacle <= w_stop;
            if (w_next_state == S_STOP && r_stop_cnt != 8'd255) begin
                r_stop_cnt <= r_stop_cnt + 8'd1;
            end
        end
    end

    assign state    = r_state;
    assign speed    = r_speed;
    assign dir      = r_dir;
    assign turn     = r_turn;
    assign obstacle = r_obstacle;
    assign stop_cnt = r_stop_cnt;

    robot_controller_checker #(.STOP_TH(STOP_TH)) u_checker (
        .clk    (clk),
        .rstn   (rstn),
        .dist_v (dist_v),
        .state  (state),
        .speed  (speed),
        .dir    (dir)
    );
endmodule

// Safety properties of the controller outputs and transitions.
module robot_controller_checker #(
    parameter logic [15:0] STOP_TH = 16'd300
) (
    input logic        clk,
    input logic        rstn,
    input logic [15:0] dist_v,
    input logic [2:0]  state,
    input logic [7:0]  speed,
    input logic        dir
);
    logic f_past_valid;

    // Marks that at least one post-reset edge has been seen.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) f_past_valid <= 1'b0;
        else       f_past_valid <= 1'b1;
    end

    a_stop_speed: assert property (@(posedge clk) disable iff (!rstn)
        (state == 3'd3) |-> (speed == 8'd0));

    a_rev_only: assert property (@(posedge clk) disable iff (!rstn)
        (dir == 1'b0) |-> (state == 3'd4));

    a_fwd_entry: assert property (@(posedge clk) disable iff (!rstn)
        (f_past_valid && state == 3'd1 && $past(state) != 3'd1 && $past(state) != 3'd0)
        |-> ($past(dist_v) >= STOP_TH));
endmodule

// File: tb/tb_robot_controller.sv
// Directed bench for robot_controller: expected states are queued as stimulus is driven
// and popped after each edge to compare state and decoded outputs.
module tb_robot_controller;
    logic        clk;
    logic        rstn;
    logic [15:0] dist_v;
    logic [2:0]  state;
    logic [7:0]  speed;
    logic        dir;
    logic        turn;
    logic        obstacle;
    logic [7:0]  stop_cnt;

    typedef struct packed {
        logic [2:0] st;
        logic [7:0] spd;
        logic       d;
        logic       t;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   exp_stops = 0;

    localparam logic [2:0] IDLE = 3'd0, FWD = 3'd1, SLOW = 3'd2,
                           STOP = 3'd3, REV = 3'd4, TURN = 3'd5;

    robot_controller dut (
        .clk      (clk),
        .rstn     (rstn),
        .dist_v   (dist_v),
        .state    (state),
        .speed    (speed),
        .dir      (dir),
        .turn     (turn),
        .obstacle (obstacle),
        .stop_cnt (stop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t table_row(input logic [2:0] s);
        exp_t e;
        e.st = s;
        case (s)
            FWD:        begin e.spd = 8'd255; e.d = 1'b1; e.t = 1'b0; end
            SLOW:       begin e.spd = 8'd128; e.d = 1'b1; e.t = 1'b0; end
            REV:        begin e.spd = 8'd128; e.d = 1'b0; e.t = 1'b0; end
            TURN:       begin e.spd = 8'd128; e.d = 1'b1; e.t = 1'b1; end
            default:    begin e.spd = 8'd0;   e.d = 1'b1; e.t = 1'b0; end
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input logic [15:0] d, input logic [2:0] es, input string tag);
        exp_t e;
        dist_v = d;
        exp_q.push_back(table_row(es));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".state"}, 16'(state), 16'(e.st));
        chk({tag, ".speed"}, 16'(speed), 16'(e.spd));
        chk({tag, ".dir"},   16'(dir),   16'(e.d));
        chk({tag, ".turn"},  16'(turn),  16'(e.t));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".state"},    16'(state),    16'(IDLE));
        chk({tag, ".speed"},    16'(speed),    16'd0);
        chk({tag, ".dir"},      16'(dir),      16'd1);
        chk({tag, ".turn"},     16'(turn),     16'd0);
        chk({tag, ".obstacle"}, 16'(obstacle), 16'd0);
        chk({tag, ".stop_cnt"}, 16'(stop_cnt), 16'd0);
    endtask

    // One STOP, 4 REV and 8 TURN cycles; the next edge is a TURN decision edge.
    task automatic obstacle_run(input string tag);
        step(16'd100, STOP, {tag, ".stop"});
        exp_stops = (exp_stops == 255) ? 255 : exp_stops + 1;
        chk({tag, ".obstacle"}, 16'(obstacle), 16'd1);
        chk({tag, ".stop_cnt"}, 16'(stop_cnt), 16'(exp_stops));
        for (int i = 0; i < 4; i++) step(16'd100, REV, {tag, ".rev"});
        for (int i = 0; i < 8; i++) step(16'd100, TURN, {tag, ".turn"});
    endtask

    initial begin
        rstn   = 1'b0;
        dist_v = 16'h7FFF;
        #12;
        check_reset_values("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("cycle0.state", 16'(state), 16'(IDLE));

        step(16'h7FFF, FWD, "boot1");
        step(16'h7FFF, FWD, "boot2");
        step(16'h7FFF, FWD, "boot3");
        step(16'd500,  SLOW, "slow500");
        step(16'd1000, FWD,  "clear1000");
        step(16'd999,  SLOW, "slow999");
        step(16'd300,  SLOW, "slow300");

        obstacle_run("run1");
        step(16'd100, TURN, "reload100");
        for (int i = 0; i < 7; i++) step(16'd5000, TURN, "ignore");
        chk("obstacle.clear", 16'(obstacle), 16'd0);
        step(16'd299, TURN, "end299");
        for (int i = 0; i < 7; i++) step(16'd5000, TURN, "ignore2");
        step(16'd300, SLOW, "end300");
        obstacle_run("run2");
        step(16'd999, SLOW, "end999");
        obstacle_run("run3");
        step(16'd1000, FWD, "end1000");

        step(16'd100, STOP, "mid.stop");
        exp_stops = exp_stops + 1;
        step(16'd100, REV, "mid.rev1");
        step(16'd100, REV, "mid.rev2");
        #2;
        rstn = 1'b0;
        #1;
        check_reset_values("async_reset");
        exp_stops = 0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step(16'h7FFF, FWD, "reboot");

        for (int n = 0; n < 256; n++) begin
            obstacle_run("sat");
            step(16'd300, SLOW, "sat.end");
        end
        chk("sat.final", 16'(stop_cnt), 16'd255);
        chk("queue.empty", 16'(exp_q.size()), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
